mips_multicycle_ctrl: RTL

- Multi-cycle control FSM for the MIPS-I CPU; replaces the purely combinational main decoder for the Avalon-bus build.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and stalls on bus waitrequest.
- Counts out multi-cycle MULT/DIV latency and signals halt or invalid-opcode termination.
- Sits between the instruction register fields and the datapath, memory-interface and PC control strobes.

---
 rtl/mips_multicycle_ctrl.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle control FSM for the MIPS-I core on the Avalon bus. Each
// instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB), stalling on
// waitrequest in FETCH and MEM. MULT/DIV variants spend MULDIV_CYCLES cycles
// in MULDIV before committing HI/LO. Undecodable instructions and JR/JALR to
// address zero end in the absorbing HALT state.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   op, funct, rt        instruction register fields (sampled in DECODE)
//   waitrequest          Avalon stall
//   jump_target_zero     JR/JALR target is 0x00000000 (halt request)
//   active               low once in HALT
//   invalid_instr        sticky undecodable-instruction flag
//   mem_read, mem_write  Avalon strobes; iord selects PC(0) / ALU result(1)
//   ir_write, pc_write   IR load and PC+4 on fetch accept
//   branch_eval, jump    one-cycle branch / jump capture
//   regwrite, regdst     register write enable, dest (00 rt, 01 rd, 10 $31)
//   alusrc, aluop        ALU operand B select and operation class
//   memtoreg, link       writeback source: load unit / return address
//   loadcontrol          load unit mode (101 = LW when idle)
//   muldiv_start         one-cycle start of the multiply/divide unit
//   hilo_write           one-cycle HI/LO commit
//   state                current state code (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt,
  input  logic               waitrequest,
  input  logic               jump_target_zero,
  output logic               active,
  output logic               invalid_instr,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch_eval,
  output logic               jump,
  output logic               regwrite,
  output logic [1:0]         regdst,
  output logic               alusrc,
  output logic               memtoreg,
  output logic               link,
  output logic [1:0]         aluop,
  output logic [2:0]         loadcontrol,
  output logic               muldiv_start,
  output logic               hilo_write,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_INVALID, C_ALUR, C_ALUI, C_LUI, C_LOAD, C_STORE, C_BRANCH, C_BRLINK,
    C_J, C_JAL, C_JR, C_JALR, C_HILO, C_MULDIV
  } iclass_t;

  // Counter holds remaining MULDIV cycles minus one; 6 bits covers 1..64.
  localparam int               CNT_W    = 6;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [2:0]       LC_LW    = 3'b101;

  state_t           state_reg, state_next;
  iclass_t          cls_reg, cls_next, dec_cls;
  logic [2:0]       lc_reg, lc_next, dec_lc;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             active_reg, active_next;
  logic             invalid_reg, invalid_next;

  // Instruction class decode from the raw IR fields.
  always_comb begin
    dec_cls = C_INVALID;
    dec_lc  = LC_LW;
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b:                 dec_cls = C_ALUR;
          6'h08:                        dec_cls = C_JR;
          6'h09:                        dec_cls = C_JALR;
          6'h11, 6'h13:                 dec_cls = C_HILO;
          6'h18, 6'h19, 6'h1a, 6'h1b:   dec_cls = C_MULDIV;
          default:                      dec_cls = C_INVALID;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: dec_cls = C_BRANCH;
          5'h10, 5'h11: dec_cls = C_BRLINK;
          default:      dec_cls = C_INVALID;
        endcase
      end
      6'h02:                                   dec_cls = C_J;
      6'h03:                                   dec_cls = C_JAL;
      6'h04, 6'h05, 6'h06, 6'h07:              dec_cls = C_BRANCH;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: dec_cls = C_ALUI;
      6'h0f: begin dec_cls = C_LUI;  dec_lc = 3'b100; end
      6'h20: begin dec_cls = C_LOAD; dec_lc = 3'b000; end
      6'h21: begin dec_cls = C_LOAD; dec_lc = 3'b010; end
      6'h22: begin dec_cls = C_LOAD; dec_lc = 3'b110; end
      6'h23: begin dec_cls = C_LOAD; dec_lc = 3'b101; end
      6'h24: begin dec_cls = C_LOAD; dec_lc = 3'b001; end
      6'h25: begin dec_cls = C_LOAD; dec_lc = 3'b011; end
      6'h26: begin dec_cls = C_LOAD; dec_lc = 3'b111; end
      6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e:      dec_cls = C_STORE;
      default:                                 dec_cls = C_INVALID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      cls_reg     <= C_INVALID;
      lc_reg      <= LC_LW;
      cnt_reg     <= '0;
      active_reg  <= 1'b1;
      invalid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cls_reg     <= cls_next;
      lc_reg      <= lc_next;
      cnt_reg     <= cnt_next;
      active_reg  <= active_next;
      invalid_reg <= invalid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cls_next     = cls_reg;
    lc_next      = lc_reg;
    cnt_next     = cnt_reg;
    active_next  = active_reg;
    invalid_next = invalid_reg;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch_eval  = 1'b0;
    jump         = 1'b0;
    regwrite     = 1'b0;
    regdst       = 2'b00;
    alusrc       = 1'b0;
    memtoreg     = 1'b0;
    link         = 1'b0;
    aluop        = 2'b00;
    loadcontrol  = LC_LW;
    muldiv_start = 1'b0;
    hilo_write   = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        if (!waitrequest) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_next = dec_cls;
        lc_next  = dec_lc;
        if (dec_cls == C_INVALID) begin
          state_next   = S_HALT;
          invalid_next = 1'b1;
          active_next  = 1'b0;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_FETCH;
        case (cls_reg)
          C_ALUR: begin aluop = 2'b10; state_next = S_WB; end
          C_ALUI: begin aluop = 2'b10; alusrc = 1'b1; state_next = S_WB; end
          C_LUI: begin
            aluop = 2'b10; alusrc = 1'b1; loadcontrol = lc_reg; state_next = S_WB;
          end
          C_LOAD:  begin alusrc = 1'b1; loadcontrol = lc_reg; state_next = S_MEM; end
          C_STORE: begin alusrc = 1'b1; state_next = S_MEM; end
          C_BRANCH: begin branch_eval = 1'b1; aluop = 2'b01; end
          C_BRLINK: begin
            branch_eval = 1'b1; aluop = 2'b01;
            regwrite = 1'b1; regdst = 2'b10; link = 1'b1;
          end
          C_J:   jump = 1'b1;
          C_JAL: begin jump = 1'b1; regwrite = 1'b1; regdst = 2'b10; link = 1'b1; end
          C_JR, C_JALR: begin
            jump = 1'b1;
            if (cls_reg == C_JALR) begin
              regwrite = 1'b1; regdst = 2'b01; link = 1'b1;
            end
            // A jump to address zero is the program's exit; the delay slot
            // is never fetched.
            if (jump_target_zero) begin
              state_next  = S_HALT;
              active_next = 1'b0;
            end
          end
          C_HILO: hilo_write = 1'b1;
          C_MULDIV: begin
            muldiv_start = 1'b1;
            cnt_next     = CNT_LOAD;
            state_next   = S_MULDIV;
          end
          default: begin
            state_next   = S_HALT;
            invalid_next = 1'b1;
            active_next  = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (cls_reg == C_LOAD) begin
          mem_read    = 1'b1;
          loadcontrol = lc_reg;
        end else begin
          mem_write = 1'b1;
        end
        if (!waitrequest) state_next = (cls_reg == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
        if (cls_reg == C_ALUR) regdst = 2'b01;
        if (cls_reg == C_LOAD || cls_reg == C_LUI) begin
          memtoreg    = 1'b1;
          loadcontrol = lc_reg;
        end
      end
      S_MULDIV: begin
        if (cnt_reg == '0) begin
          hilo_write = 1'b1;
          state_next = S_FETCH;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_HALT: begin
      end
      default: begin
        state_next   = S_HALT;
        invalid_next = 1'b1;
        active_next  = 1'b0;
      end
    endcase

    // Strobes are suppressed in the reset cycle so an instruction aborted by
    // reset never commits a register or HI/LO write.
    if (reset) begin
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      branch_eval  = 1'b0;
      jump         = 1'b0;
      regwrite     = 1'b0;
      regdst       = 2'b00;
      alusrc       = 1'b0;
      memtoreg     = 1'b0;
      link         = 1'b0;
      aluop        = 2'b00;
      loadcontrol  = LC_LW;
      muldiv_start = 1'b0;
      hilo_write   = 1'b0;
    end
  end

  assign active        = active_reg;
  assign invalid_instr = invalid_reg;
  assign state         = STATE_W'(state_reg);

endmodule
